// File: rtl/wb_queue.sv
// wb_queue: ALU/load write-back arbiter with a 4-entry ALU FIFO, a registered
// register-file/flag output stage and a registered pending-write scoreboard.
// Loads always win the output stage; ALU results wait in the FIFO in order.
// Optional feature macro: WB_BYPASS_EN lets an ALU result skip the empty FIFO
// and reach the output stage one cycle after its handshake.
module wb_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_reg,
  input  logic [15:0] alu_data,
  input  logic [2:0]  alu_flag_en,
  input  logic [2:0]  alu_flags,
  input  logic        ld_valid,
  input  logic [3:0]  ld_reg,
  input  logic [15:0] ld_data,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  output logic        Z_in,
  output logic        O_in,
  output logic        N_in,
  output logic        Z_en,
  output logic        O_en,
  output logic        N_en,
  output logic [15:0] pending
);

  // FIFO storage; flag vectors are kept in {Z,O,N} order
  logic [3:0]  regMem    [4];
  logic [15:0] dataMem   [4];
  logic [2:0]  flagEnMem [4];
  logic [2:0]  flagsMem  [4];

  logic [1:0] rdPtr;
  logic [1:0] wrPtr;
  logic [2:0] count;

  logic       aluFire;
  logic       fifoEmpty;
  logic       doPop;
  logic       doPush;
  logic       doBypass;
  logic [1:0] rdPtrNext;
  logic [1:0] wrPtrNext;
  logic [2:0] countNext;

  logic        nextWrite;
  logic [3:0]  nextReg;
  logic [15:0] nextData;
  logic [2:0]  nextFlagEn;
  logic [2:0]  nextFlags;
  logic [15:0] pendingNext;

  assign alu_ready = !rst && (count != 3'd4);
  assign aluFire   = alu_valid && alu_ready;
  assign fifoEmpty = (count == 3'd0);
  assign doPop     = !ld_valid && !fifoEmpty;

`ifdef WB_BYPASS_EN
  assign doBypass = aluFire && !ld_valid && fifoEmpty;
`else
  assign doBypass = 1'b0;
`endif

  assign doPush    = aluFire && !doBypass;
  assign rdPtrNext = doPop  ? rdPtr + 2'd1 : rdPtr;
  assign wrPtrNext = doPush ? wrPtr + 2'd1 : wrPtr;

  // Occupancy follows push minus pop; a simultaneous push and pop cancel out
  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + 3'd1;
    end else if (!doPush && doPop) begin
      countNext = count - 3'd1;
    end
  end

  // Select what the output stage shows next: load first, then FIFO head, then bypass
  always_comb begin
    nextWrite  = 1'b0;
    nextReg    = DstReg;
    nextData   = DstData;
    nextFlagEn = 3'b000;
    nextFlags  = {Z_in, O_in, N_in};
    if (ld_valid) begin
      nextWrite = 1'b1;
      nextReg   = ld_reg;
      nextData  = ld_data;
    end else if (doPop) begin
      nextWrite  = (regMem[rdPtr] != 4'd0);
      nextReg    = regMem[rdPtr];
      nextData   = dataMem[rdPtr];
      nextFlagEn = flagEnMem[rdPtr];
      nextFlags  = flagsMem[rdPtr];
    end else if (doBypass) begin
      nextWrite  = (alu_reg != 4'd0);
      nextReg    = alu_reg;
      nextData   = alu_data;
      nextFlagEn = alu_flag_en;
      nextFlags  = alu_flags;
    end
  end

  // Scoreboard of the state after this edge: surviving FIFO slots plus the output stage
  always_comb begin
    logic [1:0] slot;
    logic [1:0] offset;
    logic [3:0] entryReg;
    pendingNext = '0;
    slot        = 2'd0;
    offset      = 2'd0;
    entryReg    = 4'd0;
    for (int i = 0; i < 4; i++) begin
      slot     = 2'(i);
      offset   = slot - rdPtrNext;
      entryReg = (doPush && (slot == wrPtr)) ? alu_reg : regMem[slot];
      if ({1'b0, offset} < countNext) begin
        pendingNext[entryReg] = 1'b1;
      end
    end
    if (nextWrite) begin
      pendingNext[nextReg] = 1'b1;
    end
    pendingNext[0] = 1'b0;
  end

  // FIFO payload writes; contents need no reset because count marks validity
  always_ff @(posedge clk) begin
    if (doPush) begin
      regMem[wrPtr]    <= alu_reg;
      dataMem[wrPtr]   <= alu_data;
      flagEnMem[wrPtr] <= alu_flag_en;
      flagsMem[wrPtr]  <= alu_flags;
    end
  end

  // FIFO pointers and occupancy; reset drops every queued write
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= 2'd0;
      wrPtr <= 2'd0;
      count <= 3'd0;
    end else begin
      rdPtr <= rdPtrNext;
      wrPtr <= wrPtrNext;
      count <= countNext;
    end
  end

  // Registered register-file, flag and scoreboard outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteReg <= 1'b0;
      DstReg   <= 4'd0;
      DstData  <= 16'd0;
      Z_en     <= 1'b0;
      O_en     <= 1'b0;
      N_en     <= 1'b0;
      Z_in     <= 1'b0;
      O_in     <= 1'b0;
      N_in     <= 1'b0;
      pending  <= 16'd0;
    end else begin
      WriteReg <= nextWrite;
      DstReg   <= nextReg;
      DstData  <= nextData;
      Z_en     <= nextFlagEn[2];
      O_en     <= nextFlagEn[1];
      N_en     <= nextFlagEn[0];
      Z_in     <= nextFlags[2];
      O_in     <= nextFlags[1];
      N_in     <= nextFlags[0];
      pending  <= pendingNext;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue.
// Expectations for ALU latency depend on whether WB_BYPASS_EN is defined.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [3:0]  alu_reg = 4'd0;
  logic [15:0] alu_data = 16'd0;
  logic [2:0]  alu_flag_en = 3'b000;
  logic [2:0]  alu_flags = 3'b000;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_reg = 4'd0;
  logic [15:0] ld_data = 16'd0;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        Z_in, O_in, N_in;
  logic        Z_en, O_en, N_en;
  logic [15:0] pending;

  int checks = 0;
  int errors = 0;

  wb_queue dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_reg(alu_reg), .alu_data(alu_data),
    .alu_flag_en(alu_flag_en), .alu_flags(alu_flags),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .Z_in(Z_in), .O_in(O_in), .N_in(N_in),
    .Z_en(Z_en), .O_en(O_en), .N_en(N_en),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("[TB] FAIL reset_write got %b want 0", WriteReg); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pending got %h want 0000", pending); end
    checks++; if ({Z_en, O_en, N_en} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flag_en got %b want 000", {Z_en, O_en, N_en}); end
    checks++; if ({DstReg, DstData} !== 20'h0) begin errors++; $display("[TB] FAIL reset_dst got %h/%h want 0/0000", DstReg, DstData); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_during got %b want 0", alu_ready); end
    rst = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after got %b want 1", alu_ready); end
  endtask

  task automatic test_load();
    ld_valid = 1'b1; ld_reg = 4'd5; ld_data = 16'hBEEF;
    step();
    ld_valid = 1'b0;
    checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd5, 16'hBEEF}) begin errors++; $display("[TB] FAIL load_out got %b/%h/%h want 1/5/beef", WriteReg, DstReg, DstData); end
    checks++; if ({Z_en, O_en, N_en} !== 3'b000) begin errors++; $display("[TB] FAIL load_flag_en got %b want 000", {Z_en, O_en, N_en}); end
    checks++; if (pending !== 16'h0020) begin errors++; $display("[TB] FAIL load_pending got %h want 0020", pending); end
    step();
    checks++; if ({WriteReg, DstReg, DstData} !== {1'b0, 4'd5, 16'hBEEF}) begin errors++; $display("[TB] FAIL load_idle_hold got %b/%h/%h want 0/5/beef", WriteReg, DstReg, DstData); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("[TB] FAIL load_idle_pending got %h want 0000", pending); end
  endtask

  task automatic test_full();
    ld_valid = 1'b1; ld_reg = 4'd2; ld_data = 16'h1111;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_reg = 4'(i); alu_data = 16'(i * 256); alu_flag_en = 3'b000;
      step();
    end
    alu_reg = 4'd9; alu_data = 16'h0999;
    step();
    alu_valid = 1'b0;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b want 0", alu_ready); end
    checks++; if (pending !== 16'h001E) begin errors++; $display("[TB] FAIL full_pending got %h want 001e", pending); end
    ld_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'(i), 16'(i * 256)}) begin errors++; $display("[TB] FAIL drain_%0d got %b/%h/%h want 1/%h/%h", i, WriteReg, DstReg, DstData, 4'(i), 16'(i * 256)); end
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_ready_%0d got %b want 1", i, alu_ready); end
    end
    step();
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("[TB] FAIL full_no_extra got %b/%h want 0", WriteReg, DstReg); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("[TB] FAIL full_end_pending got %h want 0000", pending); end
  endtask

  task automatic test_reg_zero();
    alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 16'h0055; alu_flag_en = 3'b111; alu_flags = 3'b101;
    step();
    alu_valid = 1'b0;
`ifndef WB_BYPASS_EN
    checks++; if ({WriteReg, Z_en, O_en, N_en} !== 4'b0000) begin errors++; $display("[TB] FAIL zero_early got %b want 0000", {WriteReg, Z_en, O_en, N_en}); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("[TB] FAIL zero_queued_pending got %h want 0000", pending); end
    step();
`endif
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("[TB] FAIL zero_write got %b want 0", WriteReg); end
    checks++; if ({Z_en, O_en, N_en, Z_in, O_in, N_in} !== 6'b111101) begin errors++; $display("[TB] FAIL zero_flags got %b want 111101", {Z_en, O_en, N_en, Z_in, O_in, N_in}); end
    checks++; if (pending !== 16'h0000) begin errors++; $display("[TB] FAIL zero_pending got %h want 0000", pending); end
    step();
    checks++; if ({Z_en, O_en, N_en} !== 3'b000) begin errors++; $display("[TB] FAIL zero_idle_en got %b want 000", {Z_en, O_en, N_en}); end
  endtask

  task automatic test_collision();
    ld_valid = 1'b1; ld_reg = 4'd7; ld_data = 16'hAAAA;
    alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'hBBBB; alu_flag_en = 3'b010; alu_flags = 3'b010;
    step();
    ld_valid = 1'b0; alu_valid = 1'b0;
    checks++; if ({WriteReg, DstReg, DstData, Z_en, O_en, N_en} !== {1'b1, 4'd7, 16'hAAAA, 3'b000}) begin errors++; $display("[TB] FAIL coll_load got %b/%h/%h/%b want 1/7/aaaa/000", WriteReg, DstReg, DstData, {Z_en, O_en, N_en}); end
    checks++; if (pending !== 16'h0080) begin errors++; $display("[TB] FAIL coll_pending1 got %h want 0080", pending); end
    step();
    checks++; if ({WriteReg, DstReg, DstData, Z_en, O_en, N_en, O_in} !== {1'b1, 4'd7, 16'hBBBB, 3'b010, 1'b1}) begin errors++; $display("[TB] FAIL coll_alu got %b/%h/%h/%b want 1/7/bbbb/010", WriteReg, DstReg, DstData, {Z_en, O_en, N_en}); end
    checks++; if (pending !== 16'h0080) begin errors++; $display("[TB] FAIL coll_pending2 got %h want 0080", pending); end
    step();
    checks++; if ({WriteReg, pending} !== 17'h0) begin errors++; $display("[TB] FAIL coll_done got %b/%h want 0/0000", WriteReg, pending); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen [$];
    alu_flag_en = 3'b000;
    for (int c = 0; c < 6; c++) begin
      alu_valid = (c < 3);
      alu_reg = 4'(11 + c);
      alu_data = 16'(16'hC000 + c);
      step();
      if (WriteReg === 1'b1) seen.push_back(DstReg);
    end
    alu_valid = 1'b0;
    checks++; if (seen.size() !== 3) begin errors++; $display("[TB] FAIL b2b_count got %0d want 3", seen.size()); end
    for (int k = 0; k < 3 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 4'(11 + k)) begin errors++; $display("[TB] FAIL b2b_order_%0d got %h want %h", k, seen[k], 4'(11 + k)); end
    end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1; ld_reg = 4'd6; ld_data = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_reg = 4'(8 + i); alu_data = 16'(16'hD000 + i);
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++; if (pending !== 16'h0740) begin errors++; $display("[TB] FAIL mid_pending_before got %h want 0740", pending); end
    rst = 1'b1;
    step();
    checks++; if ({WriteReg, pending} !== 17'h0) begin errors++; $display("[TB] FAIL mid_reset got %b/%h want 0/0000", WriteReg, pending); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready got %b want 0", alu_ready); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (WriteReg !== 1'b0) begin errors++; $display("[TB] FAIL mid_ghost_%0d got %b/%h want 0", c, WriteReg, DstReg); end
    end
  endtask

  task automatic test_latency();
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234; alu_flag_en = 3'b000;
    step();
    alu_valid = 1'b0;
`ifndef WB_BYPASS_EN
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("[TB] FAIL lat_early got %b want 0", WriteReg); end
    checks++; if (pending !== 16'h0008) begin errors++; $display("[TB] FAIL lat_queued_pending got %h want 0008", pending); end
    step();
`endif
    checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd3, 16'h1234}) begin errors++; $display("[TB] FAIL lat_issue got %b/%h/%h want 1/3/1234", WriteReg, DstReg, DstData); end
    checks++; if (pending !== 16'h0008) begin errors++; $display("[TB] FAIL lat_pending got %h want 0008", pending); end
    step();
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("[TB] FAIL lat_single got %b want 0", WriteReg); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_full();
    test_reg_zero();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
